// File: rtl/wimax_pkg.sv
// Shared WiMAX OFDM transmit-chain definitions: modulation type, subchannel
// coding, block sizing and constellation amplitudes.
package wimax_pkg;

    typedef enum logic {
        MOD_BPSK = 1'b0,
        MOD_QPSK = 1'b1
    } mod_e;

    localparam int SUBCHAN_W = 3;
    localparam logic [SUBCHAN_W-1:0] SUBCHAN_MAX = 3'd4;

    // Largest coded block: QPSK over 16 subchannels = 192 carriers * 2 bits.
    localparam int BLK_MAX_DEF  = 384;
    localparam int IQ_W_DEF     = 8;
    localparam int BPSK_AMP_DEF = 127;
    localparam int QPSK_AMP_DEF = 91;

    // Data subcarriers per block, 12 << s; codes beyond SUBCHAN_MAX map to 0.
    function automatic logic [7:0] nsc_of(input logic [SUBCHAN_W-1:0] s);
        case (s)
            3'd0:    return 8'd12;
            3'd1:    return 8'd24;
            3'd2:    return 8'd48;
            3'd3:    return 8'd96;
            3'd4:    return 8'd192;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/sym_map_bq.sv
// Combinational BPSK/QPSK point mapper: coded bit(s) to signed I/Q rails.
module sym_map_bq
    import wimax_pkg::*;
#(
    parameter int IQ_W     = IQ_W_DEF,
    parameter int BPSK_AMP = BPSK_AMP_DEF,
    parameter int QPSK_AMP = QPSK_AMP_DEF
) (
    input  logic [1:0]      bits,
    input  logic            mod_qpsk,
    output logic [IQ_W-1:0] i,
    output logic [IQ_W-1:0] q
);

    localparam logic [IQ_W-1:0] B_POS = IQ_W'(BPSK_AMP);
    localparam logic [IQ_W-1:0] B_NEG = IQ_W'(-BPSK_AMP);
    localparam logic [IQ_W-1:0] Q_POS = IQ_W'(QPSK_AMP);
    localparam logic [IQ_W-1:0] Q_NEG = IQ_W'(-QPSK_AMP);

    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves it unassigned, which would otherwise infer a latch.
        i = '0;
        q = '0;
        if (mod_qpsk) begin
            i = bits[0] ? Q_NEG : Q_POS;
            q = bits[1] ? Q_NEG : Q_POS;
        end else begin
            i = bits[0] ? B_NEG : B_POS;
        end
    end

endmodule

// File: rtl/ofdm_sym_mapper.sv
// Takes one interleaved coded block per handshake and streams it out as one
// BPSK/QPSK constellation point per data subcarrier.
module ofdm_sym_mapper
    import wimax_pkg::*;
#(
    parameter int BLK_MAX  = BLK_MAX_DEF,
    parameter int IQ_W     = IQ_W_DEF,
    parameter int BPSK_AMP = BPSK_AMP_DEF,
    parameter int QPSK_AMP = QPSK_AMP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BLK_MAX-1:0]   in_blk,
    input  logic                 in_blk_valid,
    output logic                 in_blk_ready,
    input  logic                 mod_qpsk,
    input  logic [SUBCHAN_W-1:0] subchan_code,
    output logic [IQ_W-1:0]      sym_i,
    output logic [IQ_W-1:0]      sym_q,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic                 sym_last,
    output logic [7:0]           sym_idx,
    output logic                 cfg_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

    logic               state;
    logic [BLK_MAX-1:0] shreg;
    mod_e               mod;
    logic [7:0]         nsc;
    logic [7:0]         idx;
    logic               cfg_err_q;

    logic       accept;
    logic       code_ok;
    logic       fire;
    logic       at_last;
    logic [IQ_W-1:0] map_i;
    logic [IQ_W-1:0] map_q;

    assign in_blk_ready = (state == ST_IDLE);
    assign accept       = in_blk_valid & in_blk_ready;
    assign code_ok      = (subchan_code <= SUBCHAN_MAX);
    assign sym_valid    = (state == ST_EMIT);
    assign fire         = sym_valid & sym_ready;
    assign at_last      = (idx == nsc - 8'd1);

    // Control: state, subcarrier index and the config-error pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= 8'd0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= accept & ~code_ok;
            case (state)
                ST_IDLE: begin
                    if (accept && code_ok) begin
                        state <= ST_EMIT;
                        idx   <= 8'd0;
                    end
                end
                ST_EMIT: begin
                    if (sym_ready) begin
                        if (at_last) begin
                            state <= ST_IDLE;
                            idx   <= 8'd0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the block register carries no reset; its contents only reach the
    // outputs while in EMIT, which always follows a fresh load.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= in_blk;
            mod   <= mod_e'(mod_qpsk);
            nsc   <= nsc_of(subchan_code);
        end else if (fire) begin
            shreg <= (mod == MOD_QPSK) ? (shreg >> 2) : (shreg >> 1);
        end
    end

    sym_map_bq #(
        .IQ_W     (IQ_W),
        .BPSK_AMP (BPSK_AMP),
        .QPSK_AMP (QPSK_AMP)
    ) u_map (
        .bits     (shreg[1:0]),
        .mod_qpsk (mod == MOD_QPSK),
        .i        (map_i),
        .q        (map_q)
    );

    // Outputs derive only from registers, so they hold still during a stall.
    assign sym_i    = sym_valid ? map_i : '0;
    assign sym_q    = sym_valid ? map_q : '0;
    assign sym_idx  = idx;
    assign sym_last = at_last & sym_valid;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_ofdm_sym_mapper.sv
// Self-checking bench for ofdm_sym_mapper: block-level reference model plus
// directed scenarios with hand-computed spot values.
module tb_ofdm_sym_mapper;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [383:0] in_blk = '0;
    logic         in_blk_valid = 1'b0;
    logic         in_blk_ready;
    logic         mod_qpsk = 1'b0;
    logic [2:0]   subchan_code = 3'd0;
    logic [7:0]   sym_i;
    logic [7:0]   sym_q;
    logic         sym_valid;
    logic         sym_ready = 1'b1;
    logic         sym_last;
    logic [7:0]   sym_idx;
    logic         cfg_err;

    ofdm_sym_mapper dut (
        .clk          (clk),
        .reset        (reset),
        .in_blk       (in_blk),
        .in_blk_valid (in_blk_valid),
        .in_blk_ready (in_blk_ready),
        .mod_qpsk     (mod_qpsk),
        .subchan_code (subchan_code),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_last     (sym_last),
        .sym_idx      (sym_idx),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int i;
        int q;
        int idx;
        bit last;
    } pt_t;

    pt_t exp_q[$];
    bit  err_pend = 1'b0;

    int  test_id = 0;
    int  seen_test = -1;
    int  cycle = 0;
    int  hs_cnt;
    int  last_end;
    int  gap;
    int  last_cnt;
    int  last_idx_seen;
    int  got_i [256];
    int  got_q [256];
    int  valid_cnt [256];

    // Expand an accepted block into its expected point sequence.
    task automatic model_push(input logic [383:0] blk, input bit qpsk, input int code);
        int nsc;
        pt_t p;
        nsc = 12 << code;
        for (int k = 0; k < nsc; k++) begin
            if (qpsk) begin
                p.i = blk[2*k]   ? -91 : 91;
                p.q = blk[2*k+1] ? -91 : 91;
            end else begin
                p.i = blk[k] ? -127 : 127;
                p.q = 0;
            end
            p.idx  = k;
            p.last = (k == nsc - 1);
            exp_q.push_back(p);
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (test_id != seen_test) begin
            seen_test     = test_id;
            hs_cnt        = 0;
            last_end      = -1;
            gap           = -1;
            last_cnt      = 0;
            last_idx_seen = -1;
            for (int k = 0; k < 256; k++) valid_cnt[k] = 0;
        end
        if (!reset) begin
            exp_q.delete();
            err_pend = 1'b0;
        end else begin
            check("in_blk_ready", in_blk_ready, exp_q.size() == 0);
            check("sym_valid", sym_valid, exp_q.size() != 0);
            check("cfg_err", cfg_err, err_pend);
            if (sym_valid && exp_q.size() != 0) begin
                check("sym_i", $signed(sym_i), exp_q[0].i);
                check("sym_q", $signed(sym_q), exp_q[0].q);
                check("sym_idx", sym_idx, exp_q[0].idx);
                check("sym_last", sym_last, exp_q[0].last);
                valid_cnt[sym_idx]++;
                if (sym_ready) begin
                    got_i[sym_idx] = $signed(sym_i);
                    got_q[sym_idx] = $signed(sym_q);
                    if (sym_idx == 8'd0 && last_end >= 0) gap = cycle - last_end;
                    if (sym_last) begin
                        last_end      = cycle;
                        last_cnt++;
                        last_idx_seen = sym_idx;
                    end
                    hs_cnt++;
                    void'(exp_q.pop_front());
                end
            end
            err_pend = 1'b0;
            if (in_blk_valid && in_blk_ready) begin
                if (subchan_code <= 3'd4) model_push(in_blk, mod_qpsk, subchan_code);
                else err_pend = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and return #1 after the edge that accepted it; then
    // scramble the parameter inputs, which must no longer matter.
    task automatic offer(input logic [383:0] blk, input bit qpsk, input logic [2:0] code);
        bit ok;
        int n;
        in_blk       = blk;
        mod_qpsk     = qpsk;
        subchan_code = code;
        in_blk_valid = 1'b1;
        n = 0;
        forever begin
            ok = in_blk_ready;
            tick();
            if (ok) break;
            n++;
            if (n > 2000) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        in_blk_valid = 1'b0;
        in_blk       = ~blk;
        mod_qpsk     = ~qpsk;
        subchan_code = 3'd7;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_blk_ready && exp_q.size() == 0)) begin
            tick();
            n++;
            if (n > 2000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
        tick();
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (!(sym_valid && sym_idx == target)) begin
            tick();
            n++;
            if (n > 2000) begin
                check("idx_timeout", 0, 1);
                break;
            end
        end
    endtask

    function automatic logic [383:0] rand_blk();
        logic [383:0] b;
        for (int w = 0; w < 12; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    logic [383:0] blk_a;
    logic [383:0] blk_b;

    initial begin
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_valid", sym_valid, 0);
        check("rst_last", sym_last, 0);
        check("rst_i", sym_i, 0);
        check("rst_q", sym_q, 0);
        check("rst_idx", sym_idx, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ready", in_blk_ready, 1);

        // BPSK s=0, bits 0x0F0
        test_id = 1;
        offer(384'h0F0, 1'b0, 3'd0);
        wait_idle();
        check("t1_count", hs_cnt, 12);
        check("t1_i0", got_i[0], 127);
        check("t1_i3", got_i[3], 127);
        check("t1_i4", got_i[4], -127);
        check("t1_i7", got_i[7], -127);
        check("t1_i8", got_i[8], 127);
        check("t1_q5", got_q[5], 0);
        check("t1_last_cnt", last_cnt, 1);
        check("t1_last_idx", last_idx_seen, 11);
        check("t1_ready_after", in_blk_ready, 1);

        // QPSK s=0, bits 2'b01
        test_id = 2;
        offer(384'h1, 1'b1, 3'd0);
        wait_idle();
        check("t2_count", hs_cnt, 12);
        check("t2_i0", got_i[0], -91);
        check("t2_q0", got_q[0], 91);
        check("t2_i1", got_i[1], 91);
        check("t2_q11", got_q[11], 91);

        // QPSK s=4 with a 3-cycle stall at idx 100
        test_id = 3;
        blk_a = rand_blk();
        offer(blk_a, 1'b1, 3'd4);
        wait_idx(100);
        sym_ready = 1'b0;
        repeat (3) tick();
        sym_ready = 1'b1;
        wait_idle();
        check("t3_count", hs_cnt, 192);
        check("t3_hold100", valid_cnt[100], 4);
        check("t3_hold101", valid_cnt[101], 1);
        check("t3_last_idx", last_idx_seen, 191);

        // Two back-to-back BPSK s=1 blocks
        test_id = 4;
        blk_a = rand_blk();
        blk_b = rand_blk();
        offer(blk_a, 1'b0, 3'd1);
        offer(blk_b, 1'b0, 3'd1);
        wait_idle();
        check("t4_count", hs_cnt, 48);
        check("t4_gap", gap, 2);
        check("t4_b_i0", got_i[0], blk_b[0] ? -127 : 127);

        // Reset in the middle of a QPSK s=4 block
        test_id = 5;
        blk_a = rand_blk();
        offer(blk_a, 1'b1, 3'd4);
        wait_idx(50);
        reset = 1'b0;
        tick();
        check("t5_valid_after_rst", sym_valid, 0);
        check("t5_ready_after_rst", in_blk_ready, 1);
        reset = 1'b1;
        test_id = 6;
        offer(384'h2, 1'b1, 3'd1);
        wait_idle();
        check("t5_count", hs_cnt, 24);
        check("t5_i0", got_i[0], 91);
        check("t5_q0", got_q[0], -91);

        // Invalid subchannel code, then a normal block
        test_id = 7;
        offer(rand_blk(), 1'b1, 3'd5);
        check("t6_cfg_err", cfg_err, 1);
        check("t6_valid", sym_valid, 0);
        check("t6_ready", in_blk_ready, 1);
        tick();
        check("t6_cfg_err_clr", cfg_err, 0);
        check("t6_valid2", sym_valid, 0);
        test_id = 8;
        offer(384'h0, 1'b0, 3'd2);
        wait_idle();
        check("t6_count", hs_cnt, 48);
        check("t6_i47", got_i[47], 127);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
